// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg: shared types and helpers for the iterative multiply/divide unit
package mult_div_unit_pkg;
  localparam int WORD_W = 32;
  typedef enum logic [1:0] {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU} mduop_t;
  typedef enum logic [1:0] {IDLE, RUN, FIX} mdu_state_t;
  function automatic logic is_div(mduop_t op);
    return op == MDU_DIV || op == MDU_DIVU;
  endfunction
  function automatic logic is_signed(mduop_t op);
    return op == MDU_MULT || op == MDU_DIV;
  endfunction
endpackage

// File: rtl/mult_div_unit.sv
// mult_div_unit: radix-2 iterative MULT/MULTU/DIV/DIVU owning the HI/LO registers
module mult_div_unit
  import mult_div_unit_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  mduop_t            mduop_i,
  input  logic [WORD_W-1:0] port_a_i,
  input  logic [WORD_W-1:0] port_b_i,
  input  logic              hi_we_i,
  input  logic              lo_we_i,
  input  logic [WORD_W-1:0] wdat_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              div_zero_o,
  output logic [WORD_W-1:0] hi_o,
  output logic [WORD_W-1:0] lo_o
);
  localparam int W = WORD_W;
  mdu_state_t     state_q, state_d;
  mduop_t         op_q, op_d;
  logic [4:0]     cnt_q, cnt_d;
  logic [2*W-1:0] acc_q, acc_d, prod;
  logic [W-1:0]   b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [W-1:0]   abs_a, abs_b, quo, rmd, diff;
  logic [W:0]     sum, rem;
  logic           neg_q, neg_d, rneg_q, rneg_d, zero_q, zero_d;
  logic           done_q, done_d, dz_q, dz_d, sa, sb, ge;
  // operand magnitudes, one shift-add / shift-subtract step, and sign-corrected results
  always_comb begin
    sa    = is_signed(mduop_i) && port_a_i[W-1];
    sb    = is_signed(mduop_i) && port_b_i[W-1];
    abs_a = sa ? -port_a_i : port_a_i;
    abs_b = sb ? -port_b_i : port_b_i;
    sum   = {1'b0, acc_q[2*W-1:W]} + {1'b0, b_q};
    rem   = acc_q[2*W-1:W-1];
    ge    = rem >= {1'b0, b_q};
    diff  = rem[W-1:0] - b_q;
    prod  = neg_q ? -acc_q : acc_q;
    quo   = neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
    rmd   = rneg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
  end
  // next state: latch operands in IDLE, iterate 32 steps in RUN, commit HI/LO in FIX
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    b_d     = b_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    zero_d  = zero_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dz_d    = 1'b0;
    case (state_q)
      IDLE: begin
        hi_d = hi_we_i ? wdat_i : hi_q;
        lo_d = lo_we_i ? wdat_i : lo_q;
        if (start_i) begin
          op_d    = mduop_i;
          cnt_d   = '0;
          neg_d   = sa ^ sb;
          rneg_d  = sa;
          b_d     = abs_b;
          zero_d  = is_div(mduop_i) && port_b_i == '0;
          acc_d   = {{W{1'b0}}, zero_d ? port_a_i : abs_a};
          state_d = zero_d ? FIX : RUN;
        end
      end
      RUN: begin
        cnt_d   = cnt_q + 5'd1;
        acc_d   = is_div(op_q) ? {ge ? diff : rem[W-1:0], acc_q[W-2:0], ge}
                               : (acc_q[0] ? {sum, acc_q[W-1:1]} : {1'b0, acc_q[2*W-1:1]});
        state_d = cnt_q == 5'd31 ? FIX : RUN;
      end
      FIX: begin
        hi_d    = zero_q ? acc_q[W-1:0] : is_div(op_q) ? rmd : prod[2*W-1:W];
        lo_d    = zero_q ? '1 : is_div(op_q) ? quo : prod[W-1:0];
        done_d  = 1'b1;
        dz_d    = zero_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers; reset aborts any operation and clears HI/LO
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      op_q    <= MDU_MULT;
      cnt_q   <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      zero_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      zero_q  <= zero_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end
  assign busy_o     = state_q != IDLE;
  assign done_o     = done_q;
  assign div_zero_o = dz_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed self-checking bench for mult_div_unit
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        start = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
  mduop_t      mduop = MDU_MULT;
  logic [31:0] port_a = '0, port_b = '0, wdat = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;
  int          n_cmp = 0, n_err = 0;

  typedef struct {mduop_t op; logic [31:0] a, b, hi, lo;} vec_t;

  mult_div_unit dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .mduop_i(mduop),
    .port_a_i(port_a), .port_b_i(port_b), .hi_we_i(hi_we), .lo_we_i(lo_we),
    .wdat_i(wdat), .busy_o(busy), .done_o(done), .div_zero_o(div_zero),
    .hi_o(hi), .lo_o(lo)
  );

  always #5 clk = ~clk;

  // issue one operation and return the edge count until done (60 means timeout)
  task automatic go(input mduop_t op, input logic [31:0] a, input logic [31:0] b, output int n);
    mduop = op; port_a = a; port_b = b; start = 1'b1; n = 0;
    do begin
      @(posedge clk); #1; n++;
      if (n == 1) start = 1'b0;
    end while (!done && n < 60);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done, div_zero, hi, lo} !== 67'b0) begin
      n_err++; $display("FAIL reset: got %h exp 0", {busy, done, div_zero, hi, lo});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mult();
    int n;
    go(MDU_MULT, 32'hFFFFFFFF, 32'd2, n);
    n_cmp++;
    if (n !== 34) begin n_err++; $display("FAIL mult_latency: got %0d exp 34", n); end
    n_cmp++;
    if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFE) begin n_err++; $display("FAIL mult_signed: got %h exp ffffffff_fffffffe", {hi, lo}); end
    n_cmp++;
    if ({busy, div_zero} !== 2'b00) begin n_err++; $display("FAIL mult_flags: got %b exp 00", {busy, div_zero}); end
    go(MDU_MULTU, 32'hFFFFFFFF, 32'd2, n);
    n_cmp++;
    if ({hi, lo} !== 64'h00000001_FFFFFFFE) begin n_err++; $display("FAIL multu: got %h exp 00000001_fffffffe", {hi, lo}); end
    go(MDU_MULT, 32'hFFFFFFFD, 32'hFFFFFFFB, n);
    n_cmp++;
    if ({hi, lo} !== 64'h00000000_0000000F) begin n_err++; $display("FAIL mult_negneg: got %h exp 00000000_0000000f", {hi, lo}); end
  endtask

  task automatic test_div();
    vec_t v[4];
    int n;
    v[0] = '{MDU_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    v[1] = '{MDU_DIVU, 32'd100,      32'd7,        32'd2,        32'd14};
    v[2] = '{MDU_DIV,  32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};
    v[3] = '{MDU_DIV,  32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    for (int i = 0; i < 4; i++) begin
      go(v[i].op, v[i].a, v[i].b, n);
      n_cmp++;
      if ({n[7:0], div_zero, hi, lo} !== {8'd34, 1'b0, v[i].hi, v[i].lo}) begin
        n_err++;
        $display("FAIL div_%0d: got lat=%0d dz=%b hi=%h lo=%h exp lat=34 dz=0 hi=%h lo=%h",
                 i, n, div_zero, hi, lo, v[i].hi, v[i].lo);
      end
    end
  endtask

  task automatic test_div_zero();
    int n;
    go(MDU_DIVU, 32'd5, 32'd0, n);
    n_cmp++;
    if (n !== 2) begin n_err++; $display("FAIL dz_latency: got %0d exp 2", n); end
    n_cmp++;
    if ({div_zero, hi, lo} !== {1'b1, 32'd5, 32'hFFFFFFFF}) begin
      n_err++; $display("FAIL dz_result: got dz=%b hi=%h lo=%h exp dz=1 hi=00000005 lo=ffffffff", div_zero, hi, lo);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({done, div_zero, busy} !== 3'b000) begin n_err++; $display("FAIL dz_pulse: got %b exp 000", {done, div_zero, busy}); end
    go(MDU_DIV, 32'hFFFFFFF0, 32'd0, n);
    n_cmp++;
    if ({n[7:0], div_zero, hi, lo} !== {8'd2, 1'b1, 32'hFFFFFFF0, 32'hFFFFFFFF}) begin
      n_err++; $display("FAIL dz_signed: got lat=%0d dz=%b hi=%h lo=%h exp lat=2 dz=1 hi=fffffff0 lo=ffffffff", n, div_zero, hi, lo);
    end
  endtask

  task automatic test_ignore_busy();
    int dones = 0, dn = 0;
    logic [31:0] rhi = '0, rlo = '0;
    mduop = MDU_MULT; port_a = 32'd6; port_b = 32'd7; start = 1'b1;
    for (int i = 1; i <= 45; i++) begin
      @(posedge clk); #1;
      if (i == 1) start = 1'b0;
      if (i == 10) begin
        start = 1'b1; mduop = MDU_MULTU; port_a = 32'd100; port_b = 32'd100;
        hi_we = 1'b1; lo_we = 1'b1; wdat = 32'hAAAA5555;
      end
      if (i == 11) begin start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; end
      if (done) begin dones++; dn = i; rhi = hi; rlo = lo; end
    end
    n_cmp++;
    if (dones !== 1 || dn !== 34) begin n_err++; $display("FAIL ignore_done: got count=%0d at=%0d exp count=1 at=34", dones, dn); end
    n_cmp++;
    if ({rhi, rlo} !== 64'd42) begin n_err++; $display("FAIL ignore_result: got %h exp 00000000_0000002a", {rhi, rlo}); end
  endtask

  task automatic test_abort();
    int n, bad = 0;
    mduop = MDU_DIVU; port_a = 32'd100; port_b = 32'd7; start = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (i == 1) start = 1'b0;
    end
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL abort_busy_before: got %b exp 1", busy); end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, div_zero, hi, lo} !== 67'b0) begin
      n_err++; $display("FAIL abort_clear: got %h exp 0", {busy, done, div_zero, hi, lo});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin n_err++; $display("FAIL abort_quiet: got %0d active cycles exp 0", bad); end
    go(MDU_MULT, 32'd3, 32'd4, n);
    n_cmp++;
    if ({n[7:0], hi, lo} !== {8'd34, 32'd0, 32'd12}) begin
      n_err++; $display("FAIL abort_restart: got lat=%0d hi=%h lo=%h exp lat=34 hi=0 lo=c", n, hi, lo);
    end
  endtask

  task automatic test_direct_write();
    int n = 0;
    lo_we = 1'b1; wdat = 32'hDEADBEEF;
    @(posedge clk); #1;
    lo_we = 1'b0;
    n_cmp++;
    if (lo !== 32'hDEADBEEF) begin n_err++; $display("FAIL lo_we: got %h exp deadbeef", lo); end
    hi_we = 1'b1; wdat = 32'h12345678;
    @(posedge clk); #1;
    hi_we = 1'b0;
    n_cmp++;
    if ({hi, lo} !== 64'h12345678_DEADBEEF) begin n_err++; $display("FAIL hi_we: got %h exp 12345678_deadbeef", {hi, lo}); end
    mduop = MDU_MULTU; port_a = 32'd2; port_b = 32'd3; start = 1'b1; hi_we = 1'b1; wdat = 32'hCAFEF00D;
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0;
    n_cmp++;
    if ({busy, hi} !== {1'b1, 32'hCAFEF00D}) begin n_err++; $display("FAIL start_and_hi_we: got busy=%b hi=%h exp busy=1 hi=cafef00d", busy, hi); end
    while (!done && n < 60) begin @(posedge clk); #1; n++; end
    n_cmp++;
    if ({done, hi, lo} !== {1'b1, 32'd0, 32'd6}) begin
      n_err++; $display("FAIL start_and_hi_we_result: got done=%b hi=%h lo=%h exp done=1 hi=0 lo=6", done, hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    go(MDU_MULTU, 32'd2, 32'd3, n);
    n_cmp++;
    if ({done, lo} !== {1'b1, 32'd6}) begin n_err++; $display("FAIL b2b_first: got done=%b lo=%h exp done=1 lo=6", done, lo); end
    go(MDU_MULTU, 32'd4, 32'd5, n);
    n_cmp++;
    if ({n[7:0], hi, lo} !== {8'd34, 32'd0, 32'd20}) begin
      n_err++; $display("FAIL b2b_second: got lat=%0d hi=%h lo=%h exp lat=34 hi=0 lo=14", n, hi, lo);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_ignore_busy();
    test_abort();
    test_direct_write();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
